// File: rtl/serial_and_deser.sv
// serial_and_deser: bit-serial receiver for the bitwise-AND datapath.
// Takes two LSB-first operand streams, ANDs each qualified bit pair and
// assembles the results into an n-bit word with a one-cycle completion strobe.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      frame start (opens a frame in IDLE, aborts/resyncs in SHIFT)
//   bit_valid  qualifies a_bit/b_bit in SHIFT
//   a_bit      serial operand a, LSB first
//   b_bit      serial operand b, LSB first
//   out        last completed word, out[i] = a_i & b_i
//   out_valid  one-cycle pulse, out just updated
//   busy       frame in progress
//   frame_err  one-cycle pulse, partial frame aborted by an early start
module serial_and_deser #(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         bit_valid,
  input  logic         a_bit,
  input  logic         b_bit,
  output logic [n-1:0] out,
  output logic         out_valid,
  output logic         busy,
  output logic         frame_err
);

  localparam int unsigned CW = $clog2(n);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]   state, state_next;
  logic [CW-1:0] count, count_next;
  logic [n-1:0] shreg, shreg_next;
  logic [n-1:0] out_next;
  logic         out_valid_next;
  logic         busy_next;
  logic         frame_err_next;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      shreg     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      shreg     <= shreg_next;
      out       <= out_next;
      out_valid <= out_valid_next;
      busy      <= busy_next;
      frame_err <= frame_err_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next     = state;
    count_next     = count;
    shreg_next     = shreg;
    out_next       = out;
    out_valid_next = 1'b0;
    frame_err_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SHIFT;
          count_next = '0;
          shreg_next = '0;
        end
      end

      ST_SHIFT: begin
        if (start) begin
          // Early start: drop the partial word and resync; this cycle's bit is discarded
          frame_err_next = 1'b1;
          count_next     = '0;
          shreg_next     = '0;
        end else if (bit_valid) begin
          shreg_next[count] = a_bit & b_bit;
          if (count == CW'(n - 1)) begin
            // Last bit: publish the word including the bit just received
            out_next       = shreg_next;
            out_valid_next = 1'b1;
            state_next     = ST_IDLE;
            count_next     = '0;
          end else begin
            count_next = count + CW'(1);
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        count_next = '0;
        shreg_next = '0;
      end
    endcase

    busy_next = (state_next == ST_SHIFT);
  end

endmodule
